fast_to_slow: RTL and testbench
===============================

Name: fast_to_slow

Overview:
- Single-clock event-rate converter. Each rising edge of a level input `signal` is turned into a one-cycle fast-domain pulse (`pulse_a`).
- Every such event is queued in a pending counter and replayed as a pulse train (`pulse_b`) paced by a slow-rate strobe `slow_en`.
- Sits between a fast event source and a slow consumer that samples only on `slow_en` cycles. No event is lost unless the counter saturates.

Parameters:
- CNT_W, 8, pending-event counter width; capacity 2^CNT_W-1 events.

Ports:
- clk_a  input  1  sole clock; all state updates on rising edge
- rst_a  input  1  asynchronous, active-high reset
- slow_en  input  1  slow-rate strobe; high one clk_a cycle per slow period
- signal  input  1  event level input; each 0->1 transition is one event
- pulse_a  output  1  one-cycle pulse per detected rising edge of signal
- pulse_b  output  1  slow-paced replay pulse; changes only on slow_en cycles
- busy  output  1  high while pending count != 0 or pulse_b = 1

Behaviour:
- Reset (rst_a=1, async): signal_q=0, pulse_a=0, pending=0, pulse_b=0, busy=0. Reset mid-operation discards all pending events.
- Edge detect: signal_q <= signal every cycle. pulse_a <= signal & ~signal_q, so pulse_a is registered and 1 cycle of latency.
  - signal already high when reset is released counts as one event.
  - pulse_a is never high on two consecutive cycles.
- Pending counter: increments on a cycle with pulse_a=1. Decrements on a cycle where a pulse_b launch occurs.
  - Simultaneous increment and decrement: count unchanged.
  - Increment at all-ones: saturates, and the event is dropped.
  - Decrement at 0 is impossible, because a launch requires pending != 0.
- pulse_b update, only when slow_en=1 (otherwise held):
  - If pulse_b=1: pulse_b <= 0. This is the mandatory gap.
  - Else if pending != 0: pulse_b <= 1 and pending decrements (launch).
  - Else pulse_b stays 0.
- Result: each pulse_b pulse is exactly one slow period high and at least one slow period low. Maximum rate is one event per 2 slow periods.
- The number of pulse_b rising edges, counted at slow_en cycles, must equal the number of pulse_a pulses, provided no saturation occurs.
- Latency: a signal rise sampled at edge k gives pulse_a at k+1 and pending increment at k+2. The launch happens on the first slow_en cycle at or after k+2 on which pulse_b=0.
- slow_en held permanently high is legal: pulse_b then toggles every clk_a cycle while events are pending.
- busy = (pending != 0) | pulse_b, combinational.

Optional Feature:
- Macro FAST_TO_SLOW_OVF_EN.
- Defined: adds output `ovf` (1 bit), a sticky flag set on any increment attempted at saturation. It is cleared only by rst_a and reset value is 0.
- Undefined: no ovf port and saturation is silent; all other behaviour is identical.

Decomposition:
- Package fast_to_slow_pkg holds:
  - localparam DEFAULT_CNT_W = 8
  - typedef of the pending counter as logic [CNT_W-1:0], or an equivalent function for the max value
- One natural sub-module, rise_detect: registered 0->1 detector with async active-high reset, instantiated for signal -> pulse_a.
- Counter and pulse_b pacing stay in the top level.

Test Plan:
- Reset: rst_a=1 with signal toggling -> pulse_a=0, pulse_b=0, busy=0. Release rst_a while signal=1 -> one pulse_a, then one pulse_b.
- Sparse events: slow_en every 13 cycles, 500 random signal values each held 3 cycles, then 200 slow periods idle -> pulse_a count == pulse_b rising-edge count, busy=0.
- Burst: slow_en every 13 cycles, 200 random values each held 1 cycle -> pulse_b keeps running about 2 slow periods per event after the burst. Counts equal after 200 idle slow periods.
- Simultaneous events: pulse_a coincident with a launch while pending=3 -> pending stays 3.
- Saturation: CNT_W=2, slow_en=0, 5 rising edges -> pending=3; with FAST_TO_SLOW_OVF_EN, ovf=1. Then enable slow_en -> exactly 3 pulse_b pulses.
- Mid-operation reset: pending=4, assert rst_a -> pulse_b=0 immediately, no further pulse_b pulses, busy=0.

Source files
------------

// File: rtl/fast_to_slow_pkg.sv
// Shared types and constants for the fast_to_slow event-rate converter.
// Holds the default counter width, the replay pacing states and a max-count helper.
package fast_to_slow_pkg;

    localparam int DEFAULT_CNT_W = 8;

    // The replay output is high for exactly one slow period, then low for at least one.
    typedef enum logic {
        PACE_LOW  = 1'b0,
        PACE_HIGH = 1'b1
    } pace_state_t;

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/fast_to_slow_rise_detect.sv
// Registered 0->1 detector: one-cycle pulse, one cycle after a rising level is sampled.
// A level already high when reset releases is reported as a rise.
module rise_detect (
    input  logic clk_a,
    input  logic rst_a,
    input  logic level,
    output logic rise
);

    logic level_q;

    // NOTE: non-blocking assignments here ensure rise uses the previous level_q, not the new one.
    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/fast_to_slow.sv
// Converts rising edges of a fast-domain level into a slow_en-paced pulse train via a saturating pending counter.
// Optional sticky overflow output `ovf` is enabled by defining FAST_TO_SLOW_OVF_EN.
module fast_to_slow
    import fast_to_slow_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic clk_a,
    input  logic rst_a,
    input  logic slow_en,
    input  logic signal,
    output logic pulse_a,
    output logic pulse_b,
    output logic busy
`ifdef FAST_TO_SLOW_OVF_EN
    ,
    output logic ovf
`endif
);

    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    pace_state_t      pace_q;
    pace_state_t      pace_d;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] pending_d;
    logic             pending_nz;
    logic             launch;

    rise_detect u_rise (
        .clk_a (clk_a),
        .rst_a (rst_a),
        .level (signal),
        .rise  (pulse_a)
    );

    assign pending_nz = (pending != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        pace_d = pace_q;
        launch = 1'b0;
        if (slow_en) begin
            if (pace_q == PACE_HIGH) begin
                pace_d = PACE_LOW;
            end else if (pending_nz) begin
                pace_d = PACE_HIGH;
                launch = 1'b1;
            end
        end
    end

    // An arriving event at full count is dropped unless a launch frees a slot in the same cycle.
    always_comb begin
        pending_d = pending;
        case ({pulse_a, launch})
            2'b10:   if (pending != PEND_MAX) pending_d = pending + PEND_ONE;
            2'b01:   pending_d = pending - PEND_ONE;
            default: pending_d = pending;
        endcase
    end

    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            pace_q  <= PACE_LOW;
            pending <= '0;
        end else begin
            pace_q  <= pace_d;
            pending <= pending_d;
        end
    end

    assign pulse_b = (pace_q == PACE_HIGH);
    assign busy    = pending_nz | pulse_b;

`ifdef FAST_TO_SLOW_OVF_EN
    logic drop;

    assign drop = pulse_a & ~launch & (pending == PEND_MAX);

    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fast_to_slow.sv
// Self-checking bench for fast_to_slow: per-cycle comparison against an event-count reference model,
// plus directed reset, pacing, coincidence, saturation and mid-operation reset scenarios.
module tb_fast_to_slow;

    localparam int MAIN_MAX = 255;
    localparam int SLOW_P   = 13;

    logic clk_a   = 1'b0;
    logic rst_a   = 1'b1;
    logic slow_en = 1'b0;
    logic signal  = 1'b0;
    logic pulse_a, pulse_b, busy;

    logic se2  = 1'b0;
    logic sig2 = 1'b0;
    logic pa2, pb2, busy2;

`ifdef FAST_TO_SLOW_OVF_EN
    logic ovf, ovf2;
`endif

    always #5 clk_a = ~clk_a;

    fast_to_slow #(.CNT_W(8)) u_dut (
        .clk_a   (clk_a),
        .rst_a   (rst_a),
        .slow_en (slow_en),
        .signal  (signal),
        .pulse_a (pulse_a),
        .pulse_b (pulse_b),
        .busy    (busy)
`ifdef FAST_TO_SLOW_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    fast_to_slow #(.CNT_W(2)) u_sat (
        .clk_a   (clk_a),
        .rst_a   (rst_a),
        .slow_en (se2),
        .signal  (sig2),
        .pulse_a (pa2),
        .pulse_b (pb2),
        .busy    (busy2)
`ifdef FAST_TO_SLOW_OVF_EN
        ,
        .ovf     (ovf2)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding events as a plain integer, replay level as a bit.
    bit m_sq, m_pa, m_pb;
    int m_pend;
    int exp_events, pa_cnt, pb_cnt, pb2_cnt;
    logic prev_pb  = 1'b0;
    logic prev_pb2 = 1'b0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sq   = 1'b0;
        m_pa   = 1'b0;
        m_pb   = 1'b0;
        m_pend = 0;
    endtask

    task automatic reset_counts();
        exp_events = 0;
        pa_cnt     = 0;
        pb_cnt     = 0;
    endtask

    task automatic tick(input logic sig, input logic se);
        int launch;
        signal  = sig;
        slow_en = se;
        @(posedge clk_a);
        if (rst_a) begin
            model_reset();
        end else begin
            launch = (se && !m_pb && m_pend > 0) ? 1 : 0;
            if (se) m_pb = !m_pb && (m_pend > 0);
            m_pend = m_pend + (m_pa ? 1 : 0) - launch;
            if (m_pend > MAIN_MAX) m_pend = MAIN_MAX;
            m_pa = sig && !m_sq;
            m_sq = sig;
            if (m_pa) exp_events++;
        end
        cyc++;
        #1;
        check("pulse_a", pulse_a, m_pa);
        check("pulse_b", pulse_b, m_pb);
        check("busy", busy, (m_pend != 0) || m_pb);
        if (pulse_a) pa_cnt++;
        if (pulse_b && !prev_pb) pb_cnt++;
        prev_pb = pulse_b;
        if (pb2 && !prev_pb2) pb2_cnt++;
        prev_pb2 = pb2;
    endtask

    task automatic slow_tick(input logic sig);
        tick(sig, (cyc % SLOW_P) == 0);
    endtask

    initial begin
        logic v;
        model_reset();
        reset_counts();
        pb2_cnt = 0;

        // Reset held while signal toggles: outputs stay quiet.
        for (int i = 0; i < 8; i++) tick(logic'(i % 2), 1'b1);
        check("rst_busy", busy, 1'b0);

        // Release reset with signal already high: exactly one event end to end.
        reset_counts();
        tick(1'b1, 1'b0);
        rst_a = 1'b0;
        for (int i = 0; i < 80; i++) slow_tick(1'b1);
        check("rel_pa_cnt", pa_cnt, 1);
        check("rel_pb_cnt", pb_cnt, 1);
        check("rel_busy", busy, 1'b0);

        // Sparse random events, each value held three cycles.
        reset_counts();
        for (int i = 0; i < 500; i++) begin
            v = logic'($urandom_range(0, 1));
            for (int j = 0; j < 3; j++) slow_tick(v);
        end
        for (int i = 0; i < 300 * SLOW_P; i++) slow_tick(1'b0);
        check("sparse_pa_vs_model", pa_cnt, exp_events);
        check("sparse_pb_vs_pa", pb_cnt, pa_cnt);
        check("sparse_busy", busy, 1'b0);

        // Burst: one cycle per random value, then drain.
        reset_counts();
        for (int i = 0; i < 200; i++) slow_tick(logic'($urandom_range(0, 1)));
        for (int i = 0; i < 200 * SLOW_P; i++) slow_tick(1'b0);
        check("burst_pa_vs_model", pa_cnt, exp_events);
        check("burst_pb_vs_pa", pb_cnt, pa_cnt);
        check("burst_busy", busy, 1'b0);

        // Increment coincident with a launch leaves the count unchanged.
        reset_counts();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("sim_pend_before", u_dut.pending, 3);
        tick(1'b1, 1'b0);
        check("sim_pa_high", pulse_a, 1'b1);
        tick(1'b1, 1'b1);
        check("sim_pend_after", u_dut.pending, 3);
        check("sim_pb_launched", pulse_b, 1'b1);
        for (int i = 0; i < 200; i++) slow_tick(1'b0);
        check("sim_pb_vs_pa", pb_cnt, pa_cnt);
        check("sim_busy", busy, 1'b0);

        // Saturation on the 2-bit instance: five rises, three retained.
        for (int i = 0; i < 5; i++) begin
            sig2 = 1'b1;
            tick(1'b0, 1'b0);
            sig2 = 1'b0;
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("sat_pending", u_sat.pending, 3);
        check("sat_busy", busy2, 1'b1);
`ifdef FAST_TO_SLOW_OVF_EN
        check("sat_ovf", ovf2, 1'b1);
        check("main_ovf", ovf, 1'b0);
`endif
        pb2_cnt = 0;
        se2 = 1'b1;
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
        check("sat_pb_cnt", pb2_cnt, 3);
        check("sat_pb_idle", pb2, 1'b0);
        check("sat_busy_idle", busy2, 1'b0);
        se2 = 1'b0;

        // Mid-operation reset with pending=4 and pulse_b high.
        reset_counts();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("mid_pb_high", pulse_b, 1'b1);
        check("mid_pending", u_dut.pending, 4);
        #2;
        rst_a = 1'b1;
        model_reset();
        #1;
        check("mid_rst_pb", pulse_b, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_pending", u_dut.pending, 0);
        prev_pb = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_a = 1'b0;
        pb_cnt = 0;
        for (int i = 0; i < 200; i++) slow_tick(1'b0);
        check("mid_no_pb", pb_cnt, 0);
        check("mid_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
